// File: rtl/aes_shift_rows_stream.sv
// aes_shift_rows_stream: byte-serial AES ShiftRows / InvShiftRows engine.
// Two ping-pong banks let one block drain while the next one fills.
module aes_shift_rows_stream #(
  parameter int BYTE_W = 8,
  parameter int NB     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inverse,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_byte,
  output logic              out_last,
  output logic              busy
);

  localparam int N  = 4 * NB;
  localparam int AW = $clog2(N);

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("aes_shift_rows_stream: NB must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_st_t;

  bank_st_t          st_q [2];
  bank_st_t          st_d [2];
  logic [1:0]        mode_q;
  logic              wr_bank_q;
  logic              rd_bank_q;
  logic [AW-1:0]     wr_idx_q;
  logic [AW-1:0]     rd_idx_q;
  logic [BYTE_W-1:0] mem_q [2][N];

  logic          wr_fire;
  logic          rd_fire;
  logic          wr_end;
  logic          rd_end;
  logic [1:0]    row;
  logic [3:0]    col;
  logic [3:0]    shamt;
  logic [3:0]    src_col;
  logic [AW-1:0] rd_addr;

  assign in_ready  = (st_q[wr_bank_q] == EMPTY)
                  || (st_q[wr_bank_q] == FILLING);
  assign out_valid = (st_q[rd_bank_q] == FULL)
                  || (st_q[rd_bank_q] == DRAINING);
  assign busy      = (st_q[0] != EMPTY) || (st_q[1] != EMPTY);

  assign wr_fire = in_valid & in_ready;
  assign rd_fire = out_valid & out_ready;
  assign wr_end  = (wr_idx_q == AW'(N - 1));
  assign rd_end  = (rd_idx_q == AW'(N - 1));

  assign row = rd_idx_q[1:0];
  assign col = 4'(rd_idx_q[AW-1:2]);

  always_comb begin
    shamt = '0;
    unique case (row)
      2'd0: shamt = 4'd0;
      2'd1: shamt = 4'd1;
      2'd2: shamt = (NB == 8) ? 4'd3 : 4'd2;
      2'd3: shamt = (NB == 8) ? 4'd4 : 4'd3;
      default: shamt = '0;
    endcase
  end

  // Column rotation modulo NB; NB is not a power of two for NB = 6.
  always_comb begin
    src_col = '0;
    if (mode_q[rd_bank_q]) src_col = col + 4'(NB) - shamt;
    else                   src_col = col + shamt;
    if (src_col >= 4'(NB)) src_col = src_col - 4'(NB);
  end

  assign rd_addr  = AW'({src_col, row});
  assign out_byte = out_valid ? mem_q[rd_bank_q][rd_addr] : '0;
  assign out_last = out_valid && rd_end;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      st_d[b] = st_q[b];
      if (clear) begin
        st_d[b] = EMPTY;
      end else if (wr_fire && wr_bank_q == 1'(b)) begin
        st_d[b] = wr_end ? FULL : FILLING;
      end else if (rd_fire && rd_bank_q == 1'(b)) begin
        st_d[b] = rd_end ? EMPTY : DRAINING;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q[0]   <= EMPTY;
      st_q[1]   <= EMPTY;
      mode_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
      if (clear) begin
        mode_q    <= '0;
        wr_bank_q <= 1'b0;
        rd_bank_q <= 1'b0;
        wr_idx_q  <= '0;
        rd_idx_q  <= '0;
      end else begin
        if (wr_fire) begin
          if (wr_idx_q == '0) mode_q[wr_bank_q] <= inverse;
          if (wr_end) begin
            wr_idx_q  <= '0;
            wr_bank_q <= ~wr_bank_q;
          end else begin
            wr_idx_q <= wr_idx_q + 1'b1;
          end
        end
        if (rd_fire) begin
          if (rd_end) begin
            rd_idx_q  <= '0;
            rd_bank_q <= ~rd_bank_q;
          end else begin
            rd_idx_q <= rd_idx_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire && !clear) mem_q[wr_bank_q][wr_idx_q] <= in_byte;
  end

endmodule

// File: doc/aes_shift_rows_stream.md
Name: aes_shift_rows_stream

Overview:
Parametrised byte-serial ShiftRows / InvShiftRows engine for the AES/Rijndael datapath, sized for Nb = 4, 6 or 8 columns. It accepts one state byte per cycle in column-major order and emits the permuted state byte-serially in the same order. Two ping-pong banks let one block drain while the next one fills. Valid/ready handshakes on both sides let it sit between the S-box stage and MixColumns without global stall logic.

Parameters:
BYTE_W, 8, width of one state element in bits.
NB, 4, number of state columns; legal values 4, 6, 8 (elaboration-time assertion otherwise); block length N = 4*NB.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
clear  in  1  synchronous flush of both banks and all pointers; has priority over all handshakes.
inverse  in  1  0 = ShiftRows, 1 = InvShiftRows; sampled with the first byte (index 0) of each block.
in_valid  in  1  input byte valid.
in_ready  out  1  input byte accepted when in_valid and in_ready are both 1 on a rising edge.
in_byte  in  BYTE_W  state byte, stream index k = r + 4c.
out_valid  out  1  out_byte valid.
out_ready  in  1  consumer accepts the byte when out_valid and out_ready are both 1.
out_byte  out  BYTE_W  permuted byte.
out_last  out  1  high with the final byte (k = N-1) of a block.
busy  out  1  high when any bank is not EMPTY.

Behaviour:
- Reset is active-low and asynchronous. Clock is clk. While rst = 0: both banks EMPTY, all pointers 0, out_valid = 0, out_last = 0, busy = 0, out_byte = 0, in_ready = 1 after release.
- Row shift amounts s(r):
  - NB = 4 or 6: 0, 1, 2, 3.
  - NB = 8: 0, 1, 3, 4.
- Per-bank state machine:
  - EMPTY -> FILLING on accept of index 0. The inverse bit is latched into the bank's mode flag at this point.
  - FILLING -> FULL on accept of index N-1.
  - FULL -> DRAINING on the first output handshake.
  - DRAINING -> EMPTY on the handshake of the last byte.
- Write side:
  - wr_bank and wr_idx counters. Byte k is stored at address k.
  - in_ready = 1 iff bank[wr_bank] is EMPTY or FILLING.
  - On accept of index N-1, wr_idx wraps to 0 and wr_bank toggles.
- Read side:
  - rd_bank and rd_idx counters. out_valid = 1 iff bank[rd_bank] is FULL or DRAINING.
  - Output index k = r + 4c reads address r + 4*((c + s(r)) mod NB) when the mode flag is 0, and r + 4*((c - s(r)) mod NB) when it is 1. Modulo is over NB, not a power of two.
  - After the handshake at rd_idx = N-1: rd_idx wraps to 0 and rd_bank toggles.
- Output timing:
  - out_byte and out_last are combinational from the bank storage and rd_idx. They are held stable while out_valid = 1 and out_ready = 0.
  - Latency: first output byte is valid the cycle after the input handshake of index N-1.
  - Throughput: 1 byte/cycle sustained with out_ready held at 1.
- Simultaneous events:
  - Write to one bank and read from the other in the same cycle is legal.
  - A bank cannot be refilled in the cycle its last byte drains. It becomes writable the following cycle, giving one bubble only when both banks are occupied.
  - A mode change mid-block has no effect until the next index-0 accept.
- Backpressure: with both banks FULL or DRAINING, in_ready = 0. Data is never overwritten and never dropped.
- clear = 1 (or rst = 0) mid-block: partial block discarded, both banks EMPTY next cycle, out_valid = 0, no stale bytes emitted afterwards.
- No arithmetic is performed on data. Pointer widths are clog2(N) for indices and 1 bit for the bank select.

Test Plan:
- NB=4, inverse=0, in_byte 0x00..0x0F, out_ready=1 -> output 00,05,0A,0F,04,09,0E,03,08,0D,02,07,0C,01,06,0B. out_last only on 0B. First out_valid the cycle after 0x0F is accepted.
- NB=4, inverse=1, same input -> 00,0D,0A,07,04,01,0E,0B,08,05,02,0F,0C,09,06,03. A forward block followed by an inverse block round-trips to 0x00..0x0F.
- NB=8, inverse=0, input 0x00..0x1F:
  - Output k=1 = 0x05, k=2 = 0x0E, k=3 = 0x13.
  - Inverse of that output restores the input.
  - NB=6 row 3 wraps modulo 6.
- Backpressure, out_ready=0 throughout:
  - in_ready deasserts after 32 accepted bytes (NB=4); byte 33 is stalled.
  - Releasing out_ready drains block 1 then block 2 in order with no loss.
- Back-to-back blocks with random out_ready gaps: scoreboard matches the reference permutation; no byte is duplicated or skipped.
- Reset or clear after 7 input bytes:
  - out_valid, busy = 0, in_ready = 1.
  - A following full block 0x00..0x0F produces the first scenario's exact output.
